// File: rtl/subleq_mem.sv
// subleq_mem: RAM responder for the subleq core with a valid/ready program
// loader that fills memory from address 0 while holding the core in reset.
// Optional memory-mapped output port: define SUBLEQ_MEM_IO_PORT_EN.
module subleq_mem #(
  parameter int unsigned       ADDR_W  = 8,
  parameter int unsigned       DATA_W  = 8,
  parameter logic [ADDR_W-1:0] IO_ADDR = 8'hFF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_we,
  input  logic              i_ld_start,
  input  logic              i_ld_valid,
  input  logic [DATA_W-1:0] i_ld_data,
  input  logic              i_ld_last,
  output logic              o_ld_ready,
  output logic              o_cpu_rstn,
  output logic              o_busy,
`ifdef SUBLEQ_MEM_IO_PORT_EN
  output logic [DATA_W-1:0] o_io_data,
  output logic              o_io_valid,
`endif
  output logic [ADDR_W:0]   o_ld_count
);

  localparam int unsigned       DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RELEASE
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                ld_xfer;
  logic                core_we;
  logic                ram_core_we;

  assign o_rdata = mem[i_raddr];
  assign ld_xfer = (state == S_LOAD) && i_ld_valid && o_ld_ready;
  assign core_we = (state == S_IDLE) && i_we;

`ifdef SUBLEQ_MEM_IO_PORT_EN
  logic io_hit;
  assign io_hit      = core_we && (i_waddr == IO_ADDR);
  assign ram_core_we = core_we && !io_hit;

  // Output port register: captures core writes to IO_ADDR, valid is a one-cycle pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_io_data  <= '0;
      o_io_valid <= 1'b0;
    end else begin
      o_io_valid <= io_hit;
      if (io_hit) o_io_data <= i_wdata;
    end
  end
`else
  assign ram_core_we = core_we;
`endif

  // RAM write port: loader and core are never both active (state-exclusive)
  always_ff @(posedge i_clk) begin
    if (ld_xfer) begin
      mem[ptr] <= i_ld_data;
    end else if (ram_core_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  // Loader FSM with registered ready / core-reset / busy outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      o_ld_count <= '0;
      o_ld_ready <= 1'b0;
      o_cpu_rstn <= 1'b1;
      o_busy     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_ld_start) begin
            state      <= S_LOAD;
            ptr        <= '0;
            o_ld_count <= '0;
            o_ld_ready <= 1'b1;
            o_cpu_rstn <= 1'b0;
            o_busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (ld_xfer) begin
            ptr        <= ptr + 1'b1;
            o_ld_count <= o_ld_count + 1'b1;
            if (i_ld_last || (ptr == PTR_LAST)) begin
              state      <= S_RELEASE;
              o_ld_ready <= 1'b0;
            end
          end
        end
        S_RELEASE: begin
          state      <= S_IDLE;
          o_cpu_rstn <= 1'b1;
          o_busy     <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          o_ld_ready <= 1'b0;
          o_cpu_rstn <= 1'b1;
          o_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
